// File: rtl/pcihellocore_led_pio_ctrl.sv
// rtl/pcihellocore_led_pio_ctrl.sv - Avalon-MM LED output PIO with atomic bit ops and blink engine
//
// Purpose:
//   Drives the board LEDs from a DATA register.
//   SET/CLEAR/TOGGLE aliases allow single-write bit manipulation.
//   A prescaled phase bit inverts the BLINK_MASK bits of the output.
//
// Ports:
//   clk        - system clock, rising edge
//   reset_n    - asynchronous active-low reset
//   address    - register word address (0..7)
//   chipselect - slave select, qualifies write_n
//   write_n    - active-low write strobe
//   writedata  - write data; bits above the register width are dropped
//   readdata   - combinational, zero-extended read data (no chipselect needed)
//   out_port   - registered LED outputs

module pcihellocore_led_pio_ctrl #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PRESCALE_W  = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_SET    = 3'd1;
  localparam logic [2:0] A_CLEAR  = 3'd2;
  localparam logic [2:0] A_TOGGLE = 3'd3;
  localparam logic [2:0] A_MASK   = 3'd4;
  localparam logic [2:0] A_PERIOD = 3'd5;
  localparam logic [2:0] A_STATUS = 3'd6;

  logic [WIDTH-1:0]      r_data;
  logic [WIDTH-1:0]      r_mask;
  logic [PRESCALE_W-1:0] r_period;
  logic [PRESCALE_W-1:0] r_cnt;
  logic                  r_phase;
  logic [WIDTH-1:0]      r_out;

  logic                  w_wr;
  logic [WIDTH-1:0]      w_wd;
  logic [PRESCALE_W-1:0] w_wd_period;
  logic                  w_period_wr;

  assign w_wr        = chipselect & ~write_n;
  assign w_wd        = writedata[WIDTH-1:0];
  assign w_wd_period = writedata[PRESCALE_W-1:0];
  assign w_period_wr = w_wr && (address == A_PERIOD);

  // Host-visible registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data   <= RESET_VALUE;
      r_mask   <= '0;
      r_period <= '0;
    end else if (w_wr) begin
      case (address)
        A_DATA:   r_data   <= w_wd;
        A_SET:    r_data   <= r_data | w_wd;
        A_CLEAR:  r_data   <= r_data & ~w_wd;
        A_TOGGLE: r_data   <= r_data ^ w_wd;
        A_MASK:   r_mask   <= w_wd;
        A_PERIOD: r_period <= w_wd_period;
        default:  ;
      endcase
    end
  end

  // Blink prescaler. A period write restarts the count from phase 0, so a new
  // period shorter than the running count can never be skipped past.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_period_wr || (r_period == '0)) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == r_period) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + PRESCALE_W'(1);
    end
  end

  // Output register uses pre-edge DATA/mask/phase, giving one cycle of latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out <= RESET_VALUE;
    end else begin
      r_out <= r_data ^ (r_mask & {WIDTH{r_phase}});
    end
  end

  assign out_port = r_out;

  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:   readdata[WIDTH-1:0]      = r_data;
      A_MASK:   readdata[WIDTH-1:0]      = r_mask;
      A_PERIOD: readdata[PRESCALE_W-1:0] = r_period;
      A_STATUS: readdata[0]              = r_phase;
      default:  readdata                 = '0;
    endcase
  end

endmodule

// File: tb/tb_pcihellocore_led_pio_ctrl.sv
// tb/tb_pcihellocore_led_pio_ctrl.sv - self-checking bench for pcihellocore_led_pio_ctrl

module tb_pcihellocore_led_pio_ctrl;

  localparam int               W  = 16;
  localparam int               PW = 24;
  localparam logic [W-1:0]     RV = 16'h00A5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [W-1:0] out_port;

  int checks   = 0;
  int failures = 0;

  // Reference model: register contents plus edges elapsed since the last
  // period write; phase follows from integer division of that count.
  logic [W-1:0]  m_data;
  logic [W-1:0]  m_mask;
  logic [PW-1:0] m_period;
  longint        m_k;
  logic [W-1:0]  m_out;

  pcihellocore_led_pio_ctrl #(
    .WIDTH(W), .RESET_VALUE(RV), .PRESCALE_W(PW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  function automatic logic m_phase();
    if (m_period == '0) return 1'b0;
    return ((m_k / (longint'(m_period) + 1)) % 2) == 1;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {16'h0, m_data};
      3'd4:    return {16'h0, m_mask};
      3'd5:    return {8'h0, m_period};
      3'd6:    return {31'h0, m_phase()};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_data = RV; m_mask = '0; m_period = '0; m_k = 0; m_out = RV;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given bus cycle, then compare DUT against model
  task automatic step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
    logic [W-1:0] ph;
    chipselect = cs; write_n = wn; address = a; writedata = wd;
    @(posedge clk);
    ph    = {W{m_phase()}};
    m_out = m_data ^ (m_mask & ph);
    if (cs && !wn) begin
      case (a)
        3'd0: m_data = wd[W-1:0];
        3'd1: m_data = m_data | wd[W-1:0];
        3'd2: m_data = m_data & ~wd[W-1:0];
        3'd3: m_data = m_data ^ wd[W-1:0];
        3'd4: m_mask = wd[W-1:0];
        3'd5: begin m_period = wd[PW-1:0]; m_k = -1; end
        default: ;
      endcase
    end
    m_k++;
    #1;
    check("out_port", {16'h0, out_port}, {16'h0, m_out});
    check("readdata", readdata, m_read(a));
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    step(1'b1, 1'b0, a, wd);
  endtask

  task automatic idle(input logic [2:0] a);
    step(1'b0, 1'b1, a, 32'h0);
  endtask

  task automatic peek(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = '0;
    m_reset();
    #12 reset_n = 1'b1;

    // Reset state
    check("rst_out", {16'h0, out_port}, 32'h0000_00A5);
    peek("rst_rd0", 3'd0, 32'h0000_00A5);
    peek("rst_rd4", 3'd4, 32'h0);
    peek("rst_rd5", 3'd5, 32'h0);
    peek("rst_rd6", 3'd6, 32'h0);
    #2;

    // Atomic bit operations
    wr(3'd0, 32'h0000_F0F0);
    wr(3'd1, 32'h0000_000F); peek("set", 3'd0, 32'h0000_F0FF);
    idle(3'd0);              check("set_out", {16'h0, out_port}, 32'h0000_F0FF);
    wr(3'd2, 32'h0000_00F0); peek("clear", 3'd0, 32'h0000_F00F);
    idle(3'd0);              check("clear_out", {16'h0, out_port}, 32'h0000_F00F);
    wr(3'd3, 32'h0000_FFFF); peek("toggle", 3'd0, 32'h0000_0FF0);
    idle(3'd0);              check("toggle_out", {16'h0, out_port}, 32'h0000_0FF0);
    wr(3'd1, 32'h0); wr(3'd2, 32'h0); wr(3'd3, 32'h0);
    peek("wd0_nochange", 3'd0, 32'h0000_0FF0);

    // Truncation and write-only/reserved reads
    wr(3'd0, 32'hFFFF_1234); peek("trunc", 3'd0, 32'h0000_1234);
    peek("rd1", 3'd1, 32'h0); peek("rd2", 3'd2, 32'h0);
    peek("rd3", 3'd3, 32'h0); peek("rd7", 3'd7, 32'h0);
    wr(3'd6, 32'hFFFF_FFFF); wr(3'd7, 32'hFFFF_FFFF);
    peek("ro_data", 3'd0, 32'h0000_1234);

    // Blink: mask 3, period 3
    wr(3'd4, 32'h3); wr(3'd0, 32'h0);
    wr(3'd5, 32'h3);
    for (int i = 0; i < 4; i++) idle(3'd6);
    check("blink_pre", {30'h0, out_port[1:0]}, 32'h0);
    idle(3'd6);
    check("blink_rise", {30'h0, out_port[1:0]}, 32'h3);
    idle(3'd6);
    check("status_ph1", readdata, 32'h1);
    // cnt now 2 with phase 1: shorten the period
    wr(3'd5, 32'h1);
    peek("restart_ph0", 3'd6, 32'h0);
    for (int i = 0; i < 9; i++) idle(3'd6);
    wr(3'd5, 32'h0);
    for (int i = 0; i < 4; i++) idle(3'd6);
    check("off_out", {16'h0, out_port}, 32'h0);

    // DATA toggle coinciding with a phase toggle
    wr(3'd4, 32'h1); wr(3'd0, 32'h0);
    wr(3'd5, 32'h1);
    idle(3'd0);
    wr(3'd3, 32'h1);
    idle(3'd0);
    check("same_edge_bit0", {31'h0, out_port[0]}, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  a;
      logic [31:0] wd;
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 3'd5) wd = (wd & 32'hFF00_0000) | $urandom_range(0, 6);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd);
    end

    // Asynchronous reset mid-blink
    wr(3'd4, 32'hFFFF); wr(3'd0, 32'h5A5A); wr(3'd5, 32'h1);
    for (int i = 0; i < 3; i++) idle(3'd0);
    address = 3'd0; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h1111;
    #2 reset_n = 1'b0;
    m_reset();
    #1;
    check("arst_out", {16'h0, out_port}, 32'h0000_00A5);
    peek("arst_rd0", 3'd0, 32'h0000_00A5);
    peek("arst_rd4", 3'd4, 32'h0);
    peek("arst_rd5", 3'd5, 32'h0);
    peek("arst_rd6", 3'd6, 32'h0);
    chipselect = 1'b0; write_n = 1'b1;
    #1 reset_n = 1'b1;
    wr(3'd0, 32'h0000_BEEF);
    peek("first_wr", 3'd0, 32'h0000_BEEF);
    idle(3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
